// File: rtl/rpll_ctrl_pkg.sv
// Shared types and constants for the GW2A rPLL lock sequencer.
// Holds the controller state encoding and the fixed rPLL dynamic-control codes.
package rpll_ctrl_pkg;

  localparam int PSDA_W = 4;

  // DUTYDA code giving a 50 % duty cycle on the rPLL output.
  localparam logic [PSDA_W-1:0] DUTY_50 = 4'b1000;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    LOCKED,
    PHASE_STEP,
    FAIL
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a level signal that is asynchronous to clk.
// Cleared by the synchronous reset so downstream logic starts from a known level.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // NOTE: non-blocking assignments let both flops sample their inputs on the same
  // edge; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rpll_lock_sequencer.sv
// rPLL reset/lock sequencer with lock retry, lock-loss relock, phase stepping
// and a held system reset for the PLL clock consumers.
module rpll_lock_sequencer
  import rpll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3,
  parameter int STEP_GAP     = 8,
  parameter int DRST_CYCLES  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock_i,
  output logic              pll_reset_o,
  output logic [PSDA_W-1:0] pll_psda_o,
  output logic [PSDA_W-1:0] pll_dutyda_o,
  input  logic              relock_req_i,
  input  logic              phase_req_i,
  input  logic [PSDA_W-1:0] phase_target_i,
  output logic              phase_busy_o,
  output logic              phase_done_o,
  output logic              pll_ready_o,
  output logic              sys_rst_o,
  output logic              fail_o,
  output logic [1:0]        retry_cnt_o
);

  localparam int RST_W   = $clog2(RST_CYCLES + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int GAP_W   = $clog2(STEP_GAP + 1);
  localparam int DRST_W  = $clog2(DRST_CYCLES + 1);

  logic lock_s;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_lock_i),
    .q_o (lock_s)
  );

  state_e              state_q, state_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0]    stable_cnt_q, stable_cnt_d;
  logic [TMO_W-1:0]    timeout_cnt_q, timeout_cnt_d;
  logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [DRST_W-1:0]   drst_cnt_q, drst_cnt_d;
  logic [PSDA_W-1:0]   psda_q, psda_d;
  logic [PSDA_W-1:0]   target_q, target_d;
  logic                done_q, done_d;

  logic [STB_W-1:0]    stable_nxt;
  logic [TMO_W-1:0]    timeout_nxt;
  logic [DRST_W-1:0]   drst_nxt;
  logic [PSDA_W-1:0]   psda_inc;

  // NOTE: every variable written here gets a value before the case statement, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    retry_cnt_d   = retry_cnt_q;
    psda_d        = psda_q;
    target_d      = target_q;
    done_d        = 1'b0;
    rst_cnt_d     = '0;
    stable_cnt_d  = '0;
    timeout_cnt_d = '0;
    gap_cnt_d     = '0;
    drst_cnt_d    = '0;

    stable_nxt  = !lock_s ? '0
                : (stable_cnt_q == STB_W'(LOCK_STABLE)) ? stable_cnt_q
                : stable_cnt_q + 1'b1;
    timeout_nxt = (timeout_cnt_q == TMO_W'(LOCK_TIMEOUT)) ? timeout_cnt_q
                : timeout_cnt_q + 1'b1;
    drst_nxt    = (drst_cnt_q == DRST_W'(DRST_CYCLES)) ? drst_cnt_q
                : drst_cnt_q + 1'b1;
    psda_inc    = psda_q + 1'b1;

    case (state_q)
      RST_HOLD: begin
        if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        stable_cnt_d  = stable_nxt;
        timeout_cnt_d = timeout_nxt;
        // Lock is tested first so a simultaneous timeout never discards a good lock.
        if (stable_nxt == STB_W'(LOCK_STABLE)) begin
          state_d     = LOCKED;
          retry_cnt_d = '0;
        end else if (timeout_nxt == TMO_W'(LOCK_TIMEOUT)) begin
          if (retry_cnt_q == RETRY_W'(MAX_RETRY)) begin
            state_d = FAIL;
          end else begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            state_d     = RST_HOLD;
          end
        end
      end

      LOCKED: begin
        drst_cnt_d = drst_nxt;
        if (!lock_s || relock_req_i) begin
          state_d = RST_HOLD;
        end else if (phase_req_i) begin
          if (phase_target_i == psda_q) begin
            done_d = 1'b1;
          end else begin
            state_d  = PHASE_STEP;
            target_d = phase_target_i;
          end
        end
      end

      PHASE_STEP: begin
        drst_cnt_d = drst_nxt;
        if (!lock_s) begin
          state_d = RST_HOLD;
        end else if (gap_cnt_q == GAP_W'(STEP_GAP - 1)) begin
          psda_d = psda_inc;
          if (psda_inc == target_q) begin
            done_d  = 1'b1;
            state_d = LOCKED;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      FAIL: state_d = FAIL;

      default: state_d = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RST_HOLD;
      rst_cnt_q     <= '0;
      stable_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      retry_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      drst_cnt_q    <= '0;
      psda_q        <= '0;
      target_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      retry_cnt_q   <= retry_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      drst_cnt_q    <= drst_cnt_d;
      psda_q        <= psda_d;
      target_q      <= target_d;
      done_q        <= done_d;
    end
  end

  assign pll_ready_o  = (state_q == LOCKED) || (state_q == PHASE_STEP);
  assign pll_reset_o  = (state_q == RST_HOLD) || (state_q == FAIL);
  // Consumers leave reset only once the locked clock has run DRST_CYCLES cycles.
  assign sys_rst_o    = !(pll_ready_o && (drst_cnt_q == DRST_W'(DRST_CYCLES)));
  assign phase_busy_o = (state_q == PHASE_STEP);
  assign phase_done_o = done_q;
  assign fail_o       = (state_q == FAIL);
  assign pll_psda_o   = psda_q;
  assign pll_dutyda_o = DUTY_50;
  assign retry_cnt_o  = 2'(retry_cnt_q);

endmodule

// File: tb/tb_rpll_lock_sequencer.sv
// Directed bench for rpll_lock_sequencer: lock sequencing, retry/fail, glitch,
// phase stepping, lock loss and mid-operation reset, with hand-derived timing.
module tb_rpll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock_i;
  logic       pll_reset_o;
  logic [3:0] pll_psda_o;
  logic [3:0] pll_dutyda_o;
  logic       relock_req_i;
  logic       phase_req_i;
  logic [3:0] phase_target_i;
  logic       phase_busy_o;
  logic       phase_done_o;
  logic       pll_ready_o;
  logic       sys_rst_o;
  logic       fail_o;
  logic [1:0] retry_cnt_o;

  int tests = 0;
  int fails = 0;

  rpll_lock_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .pll_lock_i     (pll_lock_i),
    .pll_reset_o    (pll_reset_o),
    .pll_psda_o     (pll_psda_o),
    .pll_dutyda_o   (pll_dutyda_o),
    .relock_req_i   (relock_req_i),
    .phase_req_i    (phase_req_i),
    .phase_target_i (phase_target_i),
    .phase_busy_o   (phase_busy_o),
    .phase_done_o   (phase_done_o),
    .pll_ready_o    (pll_ready_o),
    .sys_rst_o      (sys_rst_o),
    .fail_o         (fail_o),
    .retry_cnt_o    (retry_cnt_o)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; sample and drive 1 ns after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [3:0] tgt);
    phase_target_i = tgt;
    phase_req_i    = 1'b1;
    tick(1);
    phase_req_i    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pll_lock_i = 1'b0; relock_req_i = 1'b0;
    phase_req_i = 1'b0; phase_target_i = 4'd0;
    tick(3);
    tests++; if (pll_reset_o !== 1'b1) begin fails++; $display("FAIL rst_pll_reset: got %0b want 1", pll_reset_o); end
    tests++; if (pll_psda_o !== 4'd0) begin fails++; $display("FAIL rst_psda: got %0d want 0", pll_psda_o); end
    tests++; if (pll_dutyda_o !== 4'b1000) begin fails++; $display("FAIL rst_duty: got %b want 1000", pll_dutyda_o); end
    tests++; if ({sys_rst_o, pll_ready_o, phase_busy_o, phase_done_o, fail_o} !== 5'b10000) begin
      fails++; $display("FAIL rst_flags: sys/rdy/busy/done/fail got %b want 10000",
                        {sys_rst_o, pll_ready_o, phase_busy_o, phase_done_o, fail_o});
    end
    tests++; if (retry_cnt_o !== 2'd0) begin fails++; $display("FAIL rst_retry: got %0d want 0", retry_cnt_o); end
    rst = 1'b0;
    tick(15);
    tests++; if (pll_reset_o !== 1'b1) begin fails++; $display("FAIL hold_15: pll_reset got %0b want 1", pll_reset_o); end
    tick(1);
    tests++; if (pll_reset_o !== 1'b0) begin fails++; $display("FAIL hold_16: pll_reset got %0b want 0", pll_reset_o); end
  endtask

  // LOCK rises 100 cycles after RESET falls; ready follows 2 sync + 64 stable cycles.
  task automatic test_lock;
    tick(100);
    pll_lock_i = 1'b1;
    tick(65);
    tests++; if (pll_ready_o !== 1'b0) begin fails++; $display("FAIL lock_early: ready got %0b want 0", pll_ready_o); end
    tick(1);
    tests++; if (pll_ready_o !== 1'b1) begin fails++; $display("FAIL lock_ready: ready got %0b want 1", pll_ready_o); end
    tests++; if (sys_rst_o !== 1'b1) begin fails++; $display("FAIL lock_sysrst_entry: got %0b want 1", sys_rst_o); end
    tick(31);
    tests++; if (sys_rst_o !== 1'b1) begin fails++; $display("FAIL sysrst_31: got %0b want 1", sys_rst_o); end
    tick(1);
    tests++; if (sys_rst_o !== 1'b0) begin fails++; $display("FAIL sysrst_32: got %0b want 0", sys_rst_o); end
  endtask

  task automatic test_phase;
    logic [3:0] exp_code;
    do_req(4'd14);
    tests++; if (phase_busy_o !== 1'b1) begin fails++; $display("FAIL step_busy: got %0b want 1", phase_busy_o); end
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin
        // A request while stepping must be dropped; the target stays 14.
        tick(4); do_req(4'd9); tick(3);
      end else begin
        tick(8);
      end
      tests++; if (pll_psda_o !== 4'(i) || phase_done_o !== (i == 14)) begin
        fails++; $display("FAIL step_up_%0d: psda=%0d done=%0b want psda=%0d done=%0b",
                          i, pll_psda_o, phase_done_o, i, (i == 14));
      end
    end
    tests++; if (phase_busy_o !== 1'b0) begin fails++; $display("FAIL step_busy_end: got %0b want 0", phase_busy_o); end
    tick(1);
    tests++; if (phase_done_o !== 1'b0) begin fails++; $display("FAIL done_pulse: got %0b want 0", phase_done_o); end
    do_req(4'd2);
    for (int i = 1; i <= 4; i++) begin
      exp_code = 4'(14 + i);
      tick(7);
      tests++; if (pll_psda_o !== 4'(13 + i)) begin fails++; $display("FAIL wrap_hold_%0d: psda=%0d want %0d", i, pll_psda_o, 4'(13 + i)); end
      tick(1);
      tests++; if (pll_psda_o !== exp_code || phase_done_o !== (i == 4)) begin
        fails++; $display("FAIL wrap_%0d: psda=%0d done=%0b want psda=%0d done=%0b",
                          i, pll_psda_o, phase_done_o, exp_code, (i == 4));
      end
    end
    tick(1);
    do_req(4'd2);
    tests++; if (phase_done_o !== 1'b1 || phase_busy_o !== 1'b0) begin
      fails++; $display("FAIL same_target: done=%0b busy=%0b want 1 0", phase_done_o, phase_busy_o);
    end
    tick(1);
    tests++; if (phase_done_o !== 1'b0 || pll_psda_o !== 4'd2) begin
      fails++; $display("FAIL same_target_after: done=%0b psda=%0d want 0 2", phase_done_o, pll_psda_o);
    end
  endtask

  task automatic test_lock_loss;
    int done_seen;
    do_req(4'd1);
    tick(14 * 8);
    tests++; if (pll_psda_o !== 4'd0) begin fails++; $display("FAIL loss_pre_psda: got %0d want 0", pll_psda_o); end
    pll_lock_i = 1'b0;
    tick(2);
    tests++; if (pll_ready_o !== 1'b1 || phase_busy_o !== 1'b1) begin
      fails++; $display("FAIL loss_sync: ready=%0b busy=%0b want 1 1", pll_ready_o, phase_busy_o);
    end
    tick(1);
    tests++; if ({pll_ready_o, sys_rst_o, phase_busy_o, phase_done_o, pll_reset_o} !== 5'b01001) begin
      fails++; $display("FAIL loss_outputs: rdy/sys/busy/done/prst got %b want 01001",
                        {pll_ready_o, sys_rst_o, phase_busy_o, phase_done_o, pll_reset_o});
    end
    pll_lock_i = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 79; i++) begin
      tick(1);
      if (phase_done_o === 1'b1) done_seen++;
    end
    tests++; if (done_seen !== 0) begin fails++; $display("FAIL loss_no_done: pulses=%0d want 0", done_seen); end
    tests++; if (pll_ready_o !== 1'b0) begin fails++; $display("FAIL relock_early: ready=%0b want 0", pll_ready_o); end
    tick(1);
    tests++; if (pll_ready_o !== 1'b1 || pll_psda_o !== 4'd0) begin
      fails++; $display("FAIL relock: ready=%0b psda=%0d want 1 0", pll_ready_o, pll_psda_o);
    end
  endtask

  task automatic test_rst_mid;
    do_req(4'd7);
    tick(7 * 8);
    tests++; if (pll_psda_o !== 4'd7) begin fails++; $display("FAIL mid_pre_psda: got %0d want 7", pll_psda_o); end
    tick(1);
    rst = 1'b1;
    tick(1);
    tests++; if ({pll_reset_o, sys_rst_o, pll_ready_o, phase_busy_o, phase_done_o, fail_o} !== 6'b110000
                 || pll_psda_o !== 4'd0 || retry_cnt_o !== 2'd0) begin
      fails++; $display("FAIL mid_rst: prst/sys/rdy/busy/done/fail=%b psda=%0d retry=%0d want 110000 0 0",
                        {pll_reset_o, sys_rst_o, pll_ready_o, phase_busy_o, phase_done_o, fail_o},
                        pll_psda_o, retry_cnt_o);
    end
    rst = 1'b0;
    tick(80);
    tests++; if (pll_ready_o !== 1'b1) begin fails++; $display("FAIL mid_relock: ready=%0b want 1", pll_ready_o); end
    phase_target_i = 4'd3;
    relock_req_i   = 1'b1;
    phase_req_i    = 1'b1;
    tick(1);
    relock_req_i   = 1'b0;
    phase_req_i    = 1'b0;
    tests++; if ({pll_ready_o, pll_reset_o, phase_busy_o} !== 3'b010 || pll_psda_o !== 4'd0) begin
      fails++; $display("FAIL relock_wins: rdy/prst/busy=%b psda=%0d want 010 0",
                        {pll_ready_o, pll_reset_o, phase_busy_o}, pll_psda_o);
    end
    tick(1);
    tests++; if (phase_done_o !== 1'b0) begin fails++; $display("FAIL relock_no_done: got %0b want 0", phase_done_o); end
  endtask

  // 1-cycle LOCK drop after 40 stable counts restarts the count.
  task automatic test_glitch;
    rst = 1'b1; pll_lock_i = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(16);
    tests++; if (pll_reset_o !== 1'b0) begin fails++; $display("FAIL glitch_wait: pll_reset=%0b want 0", pll_reset_o); end
    pll_lock_i = 1'b1;
    tick(40);
    pll_lock_i = 1'b0;
    tick(1);
    pll_lock_i = 1'b1;
    tick(65);
    tests++; if (pll_ready_o !== 1'b0) begin fails++; $display("FAIL glitch_early: ready=%0b want 0", pll_ready_o); end
    tick(1);
    tests++; if (pll_ready_o !== 1'b1) begin fails++; $display("FAIL glitch_ready: ready=%0b want 1", pll_ready_o); end
  endtask

  task automatic test_timeout;
    rst = 1'b1; pll_lock_i = 1'b0;
    tick(1);
    rst = 1'b0;
    for (int a = 1; a <= 4; a++) begin
      tick(16 + 4096 - 1);
      tests++; if (retry_cnt_o !== 2'(a - 1) || pll_reset_o !== 1'b0 || fail_o !== 1'b0) begin
        fails++; $display("FAIL attempt_%0d_end: retry=%0d prst=%0b fail=%0b want %0d 0 0",
                          a, retry_cnt_o, pll_reset_o, fail_o, a - 1);
      end
      tick(1);
      if (a < 4) begin
        tests++; if (retry_cnt_o !== 2'(a) || pll_reset_o !== 1'b1 || fail_o !== 1'b0) begin
          fails++; $display("FAIL attempt_%0d_retry: retry=%0d prst=%0b fail=%0b want %0d 1 0",
                            a, retry_cnt_o, pll_reset_o, fail_o, a);
        end
      end else begin
        tests++; if (fail_o !== 1'b1 || pll_reset_o !== 1'b1 || sys_rst_o !== 1'b1) begin
          fails++; $display("FAIL enter_fail: fail=%0b prst=%0b sys=%0b want 1 1 1", fail_o, pll_reset_o, sys_rst_o);
        end
      end
    end
    pll_lock_i = 1'b1;
    tick(300);
    tests++; if (fail_o !== 1'b1 || pll_ready_o !== 1'b0) begin
      fails++; $display("FAIL fail_sticky: fail=%0b ready=%0b want 1 0", fail_o, pll_ready_o);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tests++; if (fail_o !== 1'b0 || retry_cnt_o !== 2'd0) begin
      fails++; $display("FAIL fail_recover: fail=%0b retry=%0d want 0 0", fail_o, retry_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_phase();
    test_lock_loss();
    test_rst_mid();
    test_glitch();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
